// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the select lines of a downstream 4-to-1 mux
// through channels a, b, c, d. Each select value is held for SETTLE cycles.
// The mux output is sampled at the end of each hold, and the four samples
// are presented as one 4-bit word with a single-cycle done pulse.
//
// Handshake: start is a level request that is only looked at in IDLE.
// stop is a synchronous abort that wins over everything else, including
// start in IDLE and the final sampling edge of a scan. done is high for
// exactly one cycle, and data_out changes on that same edge.
//
// busy is a registered mirror of the FSM state (1 = SCAN) and serves as the
// state observation point.
module mux_scan_sequencer #(
   parameter int SETTLE = 2   // hold cycles per channel, legal range 1..255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       auto,
   input  logic       w_in,
   output logic       s0,
   output logic       s1,
   output logic       busy,
   output logic       done,
   output logic [3:0] data_out
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Counter value on which the current channel is sampled.
   localparam logic [7:0] LAST = 8'(SETTLE - 1);

   state_t     state;
   logic [1:0] sel;   // channel currently driven onto the mux select
   logic [7:0] cnt;   // cycles spent on the current channel
   logic [2:0] shd;   // samples of channels 0..2 for the scan in progress

   // Select lines come straight from the channel register, so they are glitch-free.
   assign s0 = sel[0];
   assign s1 = sel[1];

   // Scan FSM: channel stepping, settle timing, sampling and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sel      <= 2'd0;
         cnt      <= 8'd0;
         shd      <= 3'b000;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= 4'b0000;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  state <= SCAN;
                  sel   <= 2'd0;
                  cnt   <= 8'd0;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (stop) begin
                  // Abort: drop the partial scan and keep the previous result.
                  state <= IDLE;
                  sel   <= 2'd0;
                  cnt   <= 8'd0;
                  busy  <= 1'b0;
               end else if (cnt != LAST) begin
                  cnt <= cnt + 8'd1;
               end else begin
                  cnt <= 8'd0;
                  case (sel)
                     2'd0: begin
                        shd[0] <= w_in;
                        sel    <= 2'd1;
                     end
                     2'd1: begin
                        shd[1] <= w_in;
                        sel    <= 2'd2;
                     end
                     2'd2: begin
                        shd[2] <= w_in;
                        sel    <= 2'd3;
                     end
                     default: begin
                        // Last channel: publish the word and wrap to channel 0.
                        // In auto mode channel 0 is driven from this edge with no gap.
                        data_out <= {w_in, shd};
                        done     <= 1'b1;
                        sel      <= 2'd0;
                        if (!auto) begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end
                     end
                  endcase
               end
            end
            default: begin
               state <= IDLE;
               sel   <= 2'd0;
               cnt   <= 8'd0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer. u0 is built with SETTLE=2 and u1 with
// SETTLE=1. Each unit drives a behavioural 4-to-1 mux whose inputs
// {d,c,b,a} live in ch0/ch1.
module tb_mux_scan_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       start0 = 0, stop0 = 0, auto0 = 0;
   logic [3:0] ch0 = 4'b0000;
   logic       w0, s0_0, s1_0, busy0, done0;
   logic [3:0] data0;

   logic       start1 = 0, stop1 = 0, auto1 = 0;
   logic [3:0] ch1 = 4'b0000;
   logic       w1, s0_1, s1_1, busy1, done1;
   logic [3:0] data1;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   // Behavioural mux models.
   always_comb w0 = ch0[{s1_0, s0_0}];
   always_comb w1 = ch1[{s1_1, s0_1}];

   mux_scan_sequencer #(.SETTLE(2)) u0 (
      .clk(clk), .rst(rst), .start(start0), .stop(stop0), .auto(auto0),
      .w_in(w0), .s0(s0_0), .s1(s1_0), .busy(busy0), .done(done0),
      .data_out(data0)
   );

   mux_scan_sequencer #(.SETTLE(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .stop(stop1), .auto(auto1),
      .w_in(w1), .s0(s0_1), .s1(s1_1), .busy(busy1), .done(done1),
      .data_out(data1)
   );

   // One record per clock edge: inputs driven before the edge and
   // outputs expected just after it.
   typedef struct {
      string      name;
      bit         which;
      bit         start;
      bit         stop;
      bit         aut;
      logic [3:0] ch;
      logic [1:0] sel;
      bit         busy;
      bit         done;
      logic [3:0] data;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(string name, bit which, bit start, bit stop, bit aut,
                               logic [3:0] ch, logic [1:0] sel, bit busy, bit done,
                               logic [3:0] data);
      vec_t v;
      v.name = name; v.which = which; v.start = start; v.stop = stop; v.aut = aut;
      v.ch = ch; v.sel = sel; v.busy = busy; v.done = done; v.data = data;
      vecs.push_back(v);
   endfunction

   // Output word layout: {sel[1:0], busy, done, data[3:0]}.
   task automatic check(string name, int idx, logic [7:0] act, logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s[%0d] got sel=%b busy=%b done=%b data=%b, want sel=%b busy=%b done=%b data=%b",
                  name, idx, act[7:6], act[5], act[4], act[3:0],
                  exp[7:6], exp[5], exp[4], exp[3:0]);
      end
   endtask

   function automatic logic [7:0] outs0();
      return {s1_0, s0_0, busy0, done0, data0};
   endfunction

   function automatic logic [7:0] outs1();
      return {s1_1, s0_1, busy1, done1, data1};
   endfunction

   task automatic drive0(bit st, bit sp, bit au, logic [3:0] ch);
      @(negedge clk);
      start0 = st; stop0 = sp; auto0 = au; ch0 = ch;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single scan, SETTLE=2, a=1 b=0 c=1 d=1.
      add("single", 0, 1, 0, 0, 4'b1101, 2'b00, 1, 0, 4'b0000);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b00, 1, 0, 4'b0000);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b01, 1, 0, 4'b0000);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b01, 1, 0, 4'b0000);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b10, 1, 0, 4'b0000);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b10, 1, 0, 4'b0000);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b11, 1, 0, 4'b0000);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b11, 1, 0, 4'b0000);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b00, 0, 1, 4'b1101);
      add("single", 0, 0, 0, 0, 4'b1101, 2'b00, 0, 0, 4'b1101);
      // Abort on T7; the result of the previous scan must survive.
      add("abort7", 0, 1, 0, 0, 4'b0000, 2'b00, 1, 0, 4'b1101);
      add("abort7", 0, 0, 0, 0, 4'b0000, 2'b00, 1, 0, 4'b1101);
      add("abort7", 0, 0, 0, 0, 4'b0000, 2'b01, 1, 0, 4'b1101);
      add("abort7", 0, 0, 0, 0, 4'b0000, 2'b01, 1, 0, 4'b1101);
      add("abort7", 0, 0, 0, 0, 4'b0000, 2'b10, 1, 0, 4'b1101);
      add("abort7", 0, 0, 0, 0, 4'b0000, 2'b10, 1, 0, 4'b1101);
      add("abort7", 0, 0, 0, 0, 4'b0000, 2'b11, 1, 0, 4'b1101);
      add("abort7", 0, 0, 1, 0, 4'b0000, 2'b00, 0, 0, 4'b1101);
      add("abort7", 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b1101);
      // start together with stop in IDLE: the unit stays idle.
      add("startstop", 0, 1, 1, 0, 4'b0000, 2'b00, 0, 0, 4'b1101);
      add("startstop", 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b1101);
      add("startstop", 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b1101);
      // Abort on the final sampling edge T8: no done is produced.
      add("abort8", 0, 1, 0, 0, 4'b0000, 2'b00, 1, 0, 4'b1101);
      for (int k = 1; k <= 7; k++)
         add("abort8", 0, 0, 0, 0, 4'b0000, 2'(k >> 1), 1, 0, 4'b1101);
      add("abort8", 0, 0, 1, 0, 4'b0000, 2'b00, 0, 0, 4'b1101);
      add("abort8", 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 4'b1101);
      // Auto mode, a=0 b=1 c=1 d=0: two back-to-back scans, then auto drops at T16.
      add("auto", 0, 1, 0, 1, 4'b0110, 2'b00, 1, 0, 4'b1101);
      for (int k = 1; k <= 7; k++)
         add("auto", 0, 0, 0, 1, 4'b0110, 2'(k >> 1), 1, 0, 4'b1101);
      add("auto", 0, 0, 0, 1, 4'b0110, 2'b00, 1, 1, 4'b0110);
      for (int k = 1; k <= 7; k++)
         add("auto", 0, 0, 0, 1, 4'b0110, 2'(k >> 1), 1, 0, 4'b0110);
      add("auto", 0, 0, 0, 0, 4'b0110, 2'b00, 0, 1, 4'b0110);
      add("auto", 0, 0, 0, 0, 4'b0110, 2'b00, 0, 0, 4'b0110);
      // Inputs change mid-scan. a=1 until T2 then 0; d goes 0->1 at T5.
      add("midchg", 0, 1, 0, 0, 4'b0001, 2'b00, 1, 0, 4'b0110);
      add("midchg", 0, 0, 0, 0, 4'b0001, 2'b00, 1, 0, 4'b0110);
      add("midchg", 0, 0, 0, 0, 4'b0001, 2'b01, 1, 0, 4'b0110);
      add("midchg", 0, 0, 0, 0, 4'b0000, 2'b01, 1, 0, 4'b0110);
      add("midchg", 0, 0, 0, 0, 4'b0000, 2'b10, 1, 0, 4'b0110);
      add("midchg", 0, 0, 0, 0, 4'b1000, 2'b10, 1, 0, 4'b0110);
      add("midchg", 0, 0, 0, 0, 4'b1000, 2'b11, 1, 0, 4'b0110);
      add("midchg", 0, 0, 0, 0, 4'b1000, 2'b11, 1, 0, 4'b0110);
      add("midchg", 0, 0, 0, 0, 4'b1000, 2'b00, 0, 1, 4'b1001);
      add("midchg", 0, 0, 0, 0, 4'b1000, 2'b00, 0, 0, 4'b1001);
      // SETTLE=1 unit: a second start at T2 is ignored and nothing follows.
      add("settle1", 1, 1, 0, 0, 4'b1010, 2'b00, 1, 0, 4'b0000);
      add("settle1", 1, 0, 0, 0, 4'b1010, 2'b01, 1, 0, 4'b0000);
      add("settle1", 1, 1, 0, 0, 4'b1010, 2'b10, 1, 0, 4'b0000);
      add("settle1", 1, 0, 0, 0, 4'b1010, 2'b11, 1, 0, 4'b0000);
      add("settle1", 1, 0, 0, 0, 4'b1010, 2'b00, 0, 1, 4'b1010);
      add("settle1", 1, 0, 0, 0, 4'b1010, 2'b00, 0, 0, 4'b1010);
      add("settle1", 1, 0, 0, 0, 4'b1010, 2'b00, 0, 0, 4'b1010);

      // Reset state.
      #2;
      check("reset_u0", 0, outs0(), 8'h00);
      check("reset_u1", 0, outs1(), 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven part.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         if (vecs[i].which == 1'b0) begin
            start0 = vecs[i].start; stop0 = vecs[i].stop; auto0 = vecs[i].aut; ch0 = vecs[i].ch;
            start1 = 0; stop1 = 0; auto1 = 0;
         end else begin
            start1 = vecs[i].start; stop1 = vecs[i].stop; auto1 = vecs[i].aut; ch1 = vecs[i].ch;
            start0 = 0; stop0 = 0; auto0 = 0;
         end
         @(posedge clk);
         #1;
         if (vecs[i].which == 1'b0)
            check(vecs[i].name, i, outs0(),
                  {vecs[i].sel, vecs[i].busy, vecs[i].done, vecs[i].data});
         else
            check(vecs[i].name, i, outs1(),
                  {vecs[i].sel, vecs[i].busy, vecs[i].done, vecs[i].data});
      end

      // Reset mid-scan while {s1,s0}=10. data_out is 1001 at this point.
      drive0(1, 0, 0, 4'b1111);
      for (int k = 1; k <= 4; k++) drive0(0, 0, 0, 4'b1111);
      check("pre_rst", 0, outs0(), {2'b10, 1'b1, 1'b0, 4'b1001});
      #3;
      rst = 1'b1;
      #1;
      check("async_rst", 0, outs0(), 8'h00);
      @(negedge clk);
      check("rst_held", 0, outs0(), 8'h00);
      rst = 1'b0;
      // A fresh start is required after reset, so the unit stays idle here.
      for (int k = 0; k < 10; k++) begin
         drive0(0, 0, 0, 4'b1111);
         check("post_rst", k, outs0(), 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
